fpu_dispatch: RTL

- Initiator for the team's multi-cycle FP16 start/done cores, such as the half-precision add/sub unit.
- Accepts tagged operation requests on a valid/ready stream and buffers them in a FIFO.
- Issues one operation at a time to the core with a single-cycle start pulse, waits for done, and returns tagged results on a valid/ready response stream.
- A watchdog converts a hung core into an error response.

---
 rtl/fpu_pkg.sv | 19 +
 rtl/fpu_req_fifo.sv | 60 ++++++
 rtl/fpu_dispatch.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP16 constants, opcodes and dispatcher state encoding
package fpu_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int FP16_W = 1 + EXP_W + FRAC_W;

  localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HUNG = 2'd2
  } disp_state_e;

endpackage

// File: rtl/fpu_req_fifo.sv
// rtl/fpu_req_fifo.sv - synchronous request FIFO with registered accept flag
module fpu_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       in_ready_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [AW:0] FULLC = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             in_ready_q;

  // Occupancy after this cycle's push/pop; simultaneous push and pop cancel
  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i)      count_d = count_q + ONE;
    else if (pop_i && !push_i) count_d = count_q - ONE;
  end

  // Pointers and count; in_ready is registered so the pop never reaches req_ready combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      in_ready_q <= (count_d != FULLC);
    end
  end

  // Storage array carries no reset; entries are only read once written
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o    = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign full_o     = (count_q == FULLC);
  assign empty_o    = (count_q == '0);
  assign in_ready_o = in_ready_q;

endmodule

// File: rtl/fpu_dispatch.sv
// rtl/fpu_dispatch.sv - queues FP16 ops, issues them to a start/done core, returns tagged results
module fpu_dispatch
  import fpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             core_start,
  output logic             core_opcode,
  output logic [15:0]      core_a,
  output logic [15:0]      core_b,
  input  logic [15:0]      core_out,
  input  logic             core_done,
  output logic             busy
);

  localparam int ENTRY_W = 1 + 2*FP16_W + TAG_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int TMR_W   = $clog2(TIMEOUT);

  logic [ENTRY_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full, fifo_empty, fifo_in_ready;
  logic               push, pop;

  logic               head_op;
  logic [15:0]        head_a, head_b;
  logic [TAG_W-1:0]   head_tag;

  disp_state_e        state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               start_q, start_d;
  logic               op_q, op_d;
  logic [15:0]        a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0]   tag_r_q, tag_r_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [15:0]        rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
  logic               rsp_err_q, rsp_err_d;

  assign push = req_valid && fifo_in_ready && !fifo_full;

  fpu_req_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .wdata_i    ({req_op, req_a, req_b, req_tag}),
    .pop_i      (pop),
    .rdata_o    (fifo_rdata),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .in_ready_o (fifo_in_ready)
  );

  assign {head_op, head_a, head_b, head_tag} = fifo_rdata;

  // Issue/wait/timeout sequencing; issue only when the response slot will be free at completion
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    start_d     = 1'b0;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    tag_r_d     = tag_r_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;
    pop         = 1'b0;
    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((fifo_count != '0) && (!rsp_valid_q || rsp_ready)) begin
          pop     = 1'b1;
          op_d    = head_op;
          a_d     = head_a;
          b_d     = head_b;
          tag_r_d = head_tag;
          start_d = 1'b1;
          timer_d = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (core_done) begin
          rsp_data_d  = core_out;
          rsp_tag_d   = tag_r_q;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (timer_q == TMR_W'(TIMEOUT-1)) begin
          rsp_data_d  = FP16_QNAN;
          rsp_tag_d   = tag_r_q;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_HUNG;
        end
      end
      ST_HUNG: begin
        if (core_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand hold and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      start_q     <= 1'b0;
      op_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      tag_r_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      start_q     <= start_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_r_q     <= tag_r_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready   = fifo_in_ready;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_err     = rsp_err_q;
  assign core_start  = start_q;
  assign core_opcode = op_q;
  assign core_a      = a_q;
  assign core_b      = b_q;
  assign busy        = !fifo_empty || (state_q != ST_IDLE);

endmodule
